dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the CPU (port 0) and DMA (port 1) in front of a byte-enabled data memory.
// Handles byte/half/word lane steering, alignment checks and registered, lane-extracted load responses.
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  rq_valid,
  output logic [1:0]  rq_ready,
  input  logic        rq_we0,
  input  logic        rq_we1,
  input  logic [1:0]  rq_size0,
  input  logic [1:0]  rq_size1,
  input  logic        rq_signed0,
  input  logic        rq_signed1,
  input  logic [31:0] rq_addr0,
  input  logic [31:0] rq_addr1,
  input  logic [31:0] rq_wdata0,
  input  logic [31:0] rq_wdata1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  logic        prio;
  logic [1:0]  grant;
  logic        granted;
  logic        sel;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        legal;
  logic [3:0]  be;
  logic [31:0] wdRep;
  logic [31:0] loadData;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Grant is gated by reset so nothing reaches the memory while reset is held.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (rq_valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
      else                   grant = rq_valid;
    end
  end

  assign rq_ready = grant;
  assign granted  = |grant;
  assign sel      = grant[1];
  assign we       = sel ? rq_we1     : rq_we0;
  assign size     = sel ? rq_size1   : rq_size0;
  assign sgn      = sel ? rq_signed1 : rq_signed0;
  assign addr     = sel ? rq_addr1   : rq_addr0;
  assign wdata    = sel ? rq_wdata1  : rq_wdata0;

  always_comb begin
    legal = 1'b0;
    be    = 4'b0000;
    wdRep = wdata;
    case (size)
      2'b00: begin
        legal = 1'b1;
        be    = 4'b0001 << addr[1:0];
        wdRep = {4{wdata[7:0]}};
      end
      2'b01: begin
        legal = ~addr[0];
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdRep = {2{wdata[15:0]}};
      end
      2'b10: begin
        legal = (addr[1:0] == 2'b00);
        be    = 4'b1111;
        wdRep = wdata;
      end
      default: begin
        legal = 1'b0;
        be    = 4'b0000;
        wdRep = wdata;
      end
    endcase
  end

  always_comb begin
    laneByte = mem_rd[{addr[1:0], 3'b000} +: 8];
    laneHalf = addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size)
      2'b00:   loadData = {{24{sgn & laneByte[7]}}, laneByte};
      2'b01:   loadData = {{16{sgn & laneHalf[15]}}, laneHalf};
      default: loadData = mem_rd;
    endcase
  end

  assign mem_we = granted & we & legal & ~reset;
  assign mem_a  = granted ? addr : 32'd0;
  assign mem_be = (granted & legal) ? be : 4'b0000;
  assign mem_wd = granted ? wdRep : 32'd0;

  // The pointer moves to the losing port after every grant; responses are one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio      <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (granted) prio <= ~sel;
      rsp_valid <= grant;
      rsp_err   <= granted & ~legal;
      rsp_rdata <= (granted & legal & ~we) ? loadData : 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a byte-level reference memory plus a cycle model
// of grants and responses, with directed transactions carrying hand-computed results.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rq_valid;
  logic [1:0]  rq_ready;
  logic        rq_we0, rq_we1;
  logic [1:0]  rq_size0, rq_size1;
  logic        rq_signed0, rq_signed1;
  logic [31:0] rq_addr0, rq_addr1, rq_wdata0, rq_wdata1;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int testsRun = 0;
  int failures = 0;

  logic [31:0] envMem [0:255];
  logic [7:0]  refMem [0:1023];

  logic        lastWe;
  logic [3:0]  lastBe;
  logic [31:0] lastWd;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_we0(rq_we0), .rq_we1(rq_we1),
    .rq_size0(rq_size0), .rq_size1(rq_size1),
    .rq_signed0(rq_signed0), .rq_signed1(rq_signed1),
    .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  // Word-indexed data memory with byte enables and a combinational read.
  assign mem_rd = envMem[mem_a[9:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) envMem[mem_a[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int nBytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit isLegal(input logic [1:0] size, input logic [31:0] addr);
    return (size != 2'b11) && ((addr % nBytes(size)) == 0);
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    logic [31:0] val;
    logic signed [31:0] tmp;
    int n;
    int sh;
    n = nBytes(size);
    val = 32'd0;
    for (int k = 0; k < n; k++) val[8*k +: 8] = refMem[(addr + k) & 1023];
    if (sgn && n < 4) begin
      sh = 32 - 8 * n;
      tmp = signed'(val << sh);
      val = tmp >>> sh;
    end
    return val;
  endfunction

  // Reference model: computes grants, memory-port values and next-cycle responses from the
  // access rules, applying stores to the byte memory only at an edge not under reset.
  initial begin : compareProc
    logic        mPrio;
    logic [1:0]  g, expRspValid, pValid;
    logic [31:0] expRdata, pRdata, a, wd, expWd;
    logic        expErr, pErr, pStore, w, s, lg;
    logic [1:0]  sz;
    logic [3:0]  expBe;
    int          n;
    mPrio = 1'b0;
    expRspValid = 2'b00; expRdata = 32'd0; expErr = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        expRspValid = 2'b00; expRdata = 32'd0; expErr = 1'b0;
      end
      checkOutput("rsp_valid", rsp_valid, expRspValid);
      if (expRspValid != 2'b00) begin
        checkOutput("rsp_rdata", rsp_rdata, expRdata);
        checkOutput("rsp_err", rsp_err, expErr);
      end

      if (reset)                  g = 2'b00;
      else if (rq_valid == 2'b11) g = mPrio ? 2'b10 : 2'b01;
      else                        g = rq_valid;
      w  = g[1] ? rq_we1     : rq_we0;
      sz = g[1] ? rq_size1   : rq_size0;
      s  = g[1] ? rq_signed1 : rq_signed0;
      a  = g[1] ? rq_addr1   : rq_addr0;
      wd = g[1] ? rq_wdata1  : rq_wdata0;
      lg = isLegal(sz, a);
      n  = nBytes(sz);
      expBe = 4'b0000;
      for (int b = 0; b < 4; b++) begin
        if (b >= (a % 4) && b < (a % 4) + n) expBe[b] = 1'b1;
        expWd[8*b +: 8] = wd[8*(b % n) +: 8];
      end

      checkOutput("rq_ready", rq_ready, g);
      checkOutput("mem_we", mem_we, (g != 0) && w && lg);
      checkOutput("mem_a", mem_a, (g != 0) ? a : 32'd0);
      if (g == 2'b00) checkOutput("mem_be_idle", mem_be, 4'b0000);
      else if (lg) checkOutput("mem_be", mem_be, expBe);
      if (g != 0 && lg && w) checkOutput("mem_wd", mem_wd, expWd);

      pValid = g;
      pErr   = (g != 0) && !lg;
      pRdata = ((g != 0) && lg && !w) ? refLoad(sz, s, a) : 32'd0;
      pStore = (g != 0) && lg && w;

      @(posedge clk);
      if (reset) begin
        mPrio = 1'b0;
        expRspValid = 2'b00; expRdata = 32'd0; expErr = 1'b0;
      end else begin
        if (pStore)
          for (int k = 0; k < n; k++) refMem[(a + k) & 1023] = wd[8*k +: 8];
        if (g == 2'b01) mPrio = 1'b1;
        if (g == 2'b10) mPrio = 1'b0;
        expRspValid = pValid; expRdata = pRdata; expErr = pErr;
      end
    end
  end

  // One single-port transaction, entered and left just after a rising edge.
  task automatic applyStimulus(input int port, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      rq_we0 = we; rq_size0 = size; rq_signed0 = sgn; rq_addr0 = addr; rq_wdata0 = wdata;
    end else begin
      rq_we1 = we; rq_size1 = size; rq_signed1 = sgn; rq_addr1 = addr; rq_wdata1 = wdata;
    end
    rq_valid[port] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rq_ready[port]) break;
    end
    checkOutput("handshake", {31'd0, rq_ready[port]}, 32'd1);
    lastWe = mem_we; lastBe = mem_be; lastWd = mem_wd;
    @(posedge clk); #1;
    rq_valid[port] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      envMem[i] = {8'hC0, 8'(i), 8'h5A, ~8'(i)};
      for (int b = 0; b < 4; b++) refMem[4*i + b] = envMem[i][8*b +: 8];
    end
    reset = 1'b1;
    rq_valid = 2'b11;
    rq_we0 = 1'b1; rq_size0 = 2'b10; rq_signed0 = 1'b0; rq_addr0 = 32'h10; rq_wdata0 = 32'hDEADBEEF;
    rq_we1 = 1'b0; rq_size1 = 2'b10; rq_signed1 = 1'b0; rq_addr1 = 32'h10; rq_wdata1 = 32'h0;

    @(negedge clk);
    checkOutput("reset_ready", rq_ready, 2'b00);
    checkOutput("reset_we", mem_we, 1'b0);
    checkOutput("reset_rsp", rsp_valid, 2'b00);
    @(posedge clk); #1 reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("rr_grant", rq_ready, (k % 2) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      checkOutput("rr_rsp", rsp_valid, (k % 2) ? 2'b10 : 2'b01);
      if (k % 2) checkOutput("rr_load", rsp_rdata, 32'hDEADBEEF);
    end
    rq_valid = 2'b00;
    @(posedge clk); #1;

    applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5);
    checkOutput("sb_be", lastBe, 4'b1000);
    checkOutput("sb_wd", lastWd, 32'hA5A5A5A5);
    checkOutput("sb_we", lastWe, 1'b1);
    checkOutput("sb_rsp", rsp_valid, 2'b01);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    checkOutput("lb_signed", rsp_rdata, 32'hFFFFFFA5);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    checkOutput("lb_unsigned", rsp_rdata, 32'h000000A5);
    applyStimulus(1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    checkOutput("lb_lane0", rsp_rdata, 32'h000000BF);
    applyStimulus(1, 1'b0, 2'b00, 1'b1, 32'h100, 32'h0);
    checkOutput("lb_lane0_s", rsp_rdata, 32'hFFFFFFBF);
    applyStimulus(1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
    checkOutput("lh_lane0", rsp_rdata, 32'h00005ABF);
    for (int b = 1; b < 3; b++) applyStimulus(b % 2, 1'b0, 2'b00, 1'(b), 32'h100 + b, 32'h0);

    applyStimulus(1, 1'b1, 2'b01, 1'b0, 32'h202, 32'h00008001);
    checkOutput("sh_be", lastBe, 4'b1100);
    checkOutput("sh_wd", lastWd, 32'h80018001);
    applyStimulus(1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0);
    checkOutput("lh_signed", rsp_rdata, 32'hFFFF8001);
    checkOutput("lh_rsp", rsp_valid, 2'b10);

    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h006, 32'h11111111);
    checkOutput("mis_we", lastWe, 1'b0);
    checkOutput("mis_err", rsp_err, 1'b1);
    checkOutput("mis_rdata", rsp_rdata, 32'h0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h004, 32'h0);
    checkOutput("mis_unchanged", rsp_rdata, 32'hC0015AFE);
    checkOutput("mis_ok", rsp_err, 1'b0);
    applyStimulus(1, 1'b0, 2'b11, 1'b0, 32'h008, 32'h0);
    checkOutput("sz3_err", rsp_err, 1'b1);
    checkOutput("sz3_rdata", rsp_rdata, 32'h0);
    applyStimulus(1, 1'b1, 2'b01, 1'b0, 32'h201, 32'hFFFF);
    checkOutput("half_odd_err", rsp_err, 1'b1);
    checkOutput("half_odd_we", lastWe, 1'b0);

    rq_we1 = 1'b1; rq_size1 = 2'b10; rq_addr1 = 32'h300; rq_wdata1 = 32'h12345678;
    rq_valid = 2'b10;
    @(negedge clk);
    checkOutput("rst_grant", rq_ready, 2'b10);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_we", mem_we, 1'b0);
    checkOutput("rst_async_ready", rq_ready, 2'b00);
    @(posedge clk); #1;
    checkOutput("rst_no_rsp", rsp_valid, 2'b00);
    rq_valid = 2'b00;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_after_rsp", rsp_valid, 2'b00);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    checkOutput("rst_no_write", rsp_rdata, 32'hC0C05A3F);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++)
      checkOutput("mem_image", envMem[i],
                  {refMem[4*i+3], refMem[4*i+2], refMem[4*i+1], refMem[4*i]});

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
